count_seq: RTL and testbench
============================

# count_seq

Registered control stage wrapped around the 16-bit count next-state logic: holds the count register, sequences run/stop via a small FSM, accepts parallel loads through a valid/ready handshake, and flags terminal count. It sits directly downstream of the combinational incrementer/load-mux and feeds the count value back to it each cycle.

## Interface
- WIDTH, 16, counter width in bits.
- AUTO_RELOAD, 1, 1 = reload from the reload register on wrap and keep running; 0 = stop at all-ones.
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous clear: count to 0, FSM to IDLE.
- start  in  1  one-cycle request to begin counting.
- en  in  1  count enable; increments only when high in RUN.
- ld_valid  in  1  load request.
- ld_data  in  WIDTH  load value.
- ld_ready  out  1  load can be accepted this cycle.
- cnt  out  WIDTH  registered count.
- tc  out  1  one-cycle pulse, cycle after a wrap/stop at terminal count.
- ovf  out  1  sticky terminal-count flag.
- ovf_ack  in  1  clears ovf.

## Operation
- Priority per cycle: rst > clr > load > start > increment.
- FSM states: IDLE, RUN, DONE.
  - IDLE: cnt held. start -> RUN. Accepted load -> stays IDLE.
  - RUN: if en, cnt <= cnt+1 (mod 2^WIDTH, no wider carry). At cnt == all-ones with en: AUTO_RELOAD=1 -> cnt <= reload, stay RUN; AUTO_RELOAD=0 -> cnt held at all-ones, -> DONE. en low: cnt held.
  - DONE: cnt held. start -> RUN with cnt <= reload. Accepted load -> IDLE.
- ld_ready = 1 in IDLE and DONE, 0 in RUN, 0 while rst or clr high. Load accepted when ld_valid && ld_ready: cnt <= ld_data, reload <= ld_data.
- Load and start in same cycle: load wins, start ignored, FSM -> IDLE.
- clr: cnt <= 0, FSM -> IDLE, tc <= 0; reload register and ovf untouched.
- Terminal event = (RUN && en && cnt == all-ones). Sets tc next cycle, sets ovf.
- ovf: set on terminal event, cleared by ovf_ack; set and ack same cycle -> ovf stays 1.
- start in RUN ignored.

## Timing
- Reset values: cnt=0, reload=0, state=IDLE, ld_ready=1 after reset deasserts (0 during), tc=0, ovf=0.
- All outputs registered except ld_ready (combinational from state, rst, clr).
- Load: accepted at edge N -> cnt == ld_data from N+1.
- Increment latency 1 cycle; start at edge N -> first increment at edge N+1 if en.
- tc high exactly one cycle, the cycle cnt shows wrapped/held value.
- rst or clr mid-RUN: takes effect at that edge; no tc generated even if terminal event coincides.

## Structure
- Package count_pkg: state enum (IDLE, RUN, DONE), default WIDTH constant, all-ones terminal constant function of WIDTH.
- One sub-module count_next: combinational next-count (increment, load mux, clear) from cnt, ld_data, reload and selects; count_seq holds FSM, registers, handshake and flags.

## Test plan
- Reset, then load 0x1234, start, en=1 for 3 cycles -> cnt 0x1234, 0x1235, 0x1236, 0x1237; ld_ready=0 in RUN.
- AUTO_RELOAD=1, load 0xFFFE, start, en=1 -> cnt 0xFFFF, then 0xFFFE with tc=1 one cycle, ovf=1 until ovf_ack.
- AUTO_RELOAD=0, load 0xFFFF, start, en=1 -> DONE, cnt held 0xFFFF, tc one pulse; start -> cnt 0xFFFF (reload) in RUN.
- RUN with en toggling 1,0,1 from 0x0010 -> 0x0011, 0x0011, 0x0012.
- clr at terminal cycle from 0xFFFF -> cnt 0, IDLE, tc stays 0, ovf unchanged; ovf set and ovf_ack same cycle -> ovf=1.
- ld_valid with ld_data 0xA5A5 and start same cycle in IDLE -> cnt 0xA5A5, state IDLE, no increment.

Source files
------------

// File: rtl/count_pkg.sv
// count_pkg: shared types and constants for the count_seq block.
//   state_t    : sequencing FSM states (IDLE, RUN, DONE)
//   cnt_sel_t  : next-count source select driven by the FSM into count_next
//   DEF_WIDTH  : default counter width
//   all_ones() : terminal-count value for a given width
package count_pkg;

   localparam int DEF_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      SEL_HOLD   = 3'd0,
      SEL_INC    = 3'd1,
      SEL_LOAD   = 3'd2,
      SEL_RELOAD = 3'd3,
      SEL_CLEAR  = 3'd4
   } cnt_sel_t;

   // Shifting by 64 yields 0, and 0 - 1 is all-ones, so w = 64 also works.
   function automatic logic [63:0] all_ones(input int w);
      return (64'h1 << w) - 64'h1;
   endfunction

endpackage

// File: rtl/count_seq_if.sv
// count_seq_if: parallel-load valid/ready handshake.
//   ld_valid : load request (master -> slave)
//   ld_data  : load value   (master -> slave)
//   ld_ready : load can be accepted this cycle (slave -> master)
interface count_seq_if #(
   parameter int WIDTH = count_pkg::DEF_WIDTH
);
   logic             ld_valid;
   logic [WIDTH-1:0] ld_data;
   logic             ld_ready;

   modport master (output ld_valid, output ld_data, input ld_ready);
   modport slave  (input ld_valid, input ld_data, output ld_ready);
endinterface

// File: rtl/count_next.sv
// count_next: combinational next-count mux.
//   cnt     : current count
//   ld_data : parallel load value
//   reload  : stored reload value
//   sel     : source select from the sequencing FSM
//   cnt_nxt : value to be registered at the next edge
module count_next
   import count_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] cnt,
   input  logic [WIDTH-1:0] ld_data,
   input  logic [WIDTH-1:0] reload,
   input  cnt_sel_t         sel,
   output logic [WIDTH-1:0] cnt_nxt
);

   always_comb begin
      cnt_nxt = cnt;
      case (sel)
         SEL_HOLD:   cnt_nxt = cnt;
         // Wraps modulo 2^WIDTH; no carry beyond WIDTH is kept.
         SEL_INC:    cnt_nxt = cnt + WIDTH'(1);
         SEL_LOAD:   cnt_nxt = ld_data;
         SEL_RELOAD: cnt_nxt = reload;
         SEL_CLEAR:  cnt_nxt = '0;
         default:    cnt_nxt = cnt;
      endcase
   end

endmodule

// File: rtl/count_seq.sv
// count_seq: registered control stage for a WIDTH-bit counter.
//   clk, rst    : clock and synchronous active-high reset
//   clr         : synchronous clear (count to 0, FSM to IDLE)
//   start       : request to begin counting
//   en          : count enable while running
//   ld          : load handshake (slave side)
//   cnt         : registered count
//   tc          : one-cycle terminal-count pulse
//   ovf, ovf_ack: sticky terminal-count flag and its clear
//
// state | meaning
// IDLE  | count held, loads accepted, start begins counting
// RUN   | increments on en, loads refused, start ignored
// DONE  | held at all-ones; start reloads and runs, load returns to IDLE
module count_seq
   import count_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter bit AUTO_RELOAD = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             start,
   input  logic             en,
   count_seq_if.slave       ld,
   output logic [WIDTH-1:0] cnt,
   output logic             tc,
   output logic             ovf,
   input  logic             ovf_ack
);

   localparam logic [WIDTH-1:0] TERM = WIDTH'(all_ones(WIDTH));

   state_t           state, state_nxt;
   cnt_sel_t         sel;
   logic [WIDTH-1:0] reload;
   logic [WIDTH-1:0] cnt_nxt;
   logic             ready;
   logic             ld_acc;
   logic             term;

   // ready already excludes rst and clr, so a load can never slip past them.
   assign ready    = (state != RUN) && !rst && !clr;
   assign ld.ld_ready = ready;
   assign ld_acc   = ld.ld_valid && ready;

   count_next #(.WIDTH(WIDTH)) u_next (
      .cnt     (cnt),
      .ld_data (ld.ld_data),
      .reload  (reload),
      .sel     (sel),
      .cnt_nxt (cnt_nxt)
   );

   always_comb begin
      state_nxt = state;
      sel       = SEL_HOLD;
      term      = 1'b0;
      if (clr) begin
         state_nxt = IDLE;
         sel       = SEL_CLEAR;
      end else if (ld_acc) begin
         state_nxt = IDLE;
         sel       = SEL_LOAD;
      end else begin
         case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
               if (en) begin
                  if (cnt == TERM) begin
                     term = 1'b1;
                     if (AUTO_RELOAD) begin
                        sel = SEL_RELOAD;
                     end else begin
                        sel       = SEL_HOLD;
                        state_nxt = DONE;
                     end
                  end else begin
                     sel = SEL_INC;
                  end
               end
            end
            DONE: begin
               if (start) begin
                  state_nxt = RUN;
                  sel       = SEL_RELOAD;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         reload <= '0;
         tc     <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         tc    <= term;
         if (ld_acc) reload <= ld.ld_data;
         // A terminal event in the same cycle as an ack keeps the flag set.
         if (term)         ovf <= 1'b1;
         else if (ovf_ack) ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_count_seq.sv
// tb_count_seq: runs two count_seq instances (AUTO_RELOAD = 1 and 0) from the
// same stimulus and compares both against a behavioural reference model.
module tb_count_seq;

   localparam int W = 16;
   localparam logic [W-1:0] MAXV = 16'hFFFF;
   localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

   logic clk, rst, clr, start, en, ld_valid, ovf_ack;
   logic [W-1:0] ld_data;

   logic [W-1:0] cnt_a, cnt_b;
   logic tc_a, tc_b, ovf_a, ovf_b;

   count_seq_if #(.WIDTH(W)) if_a ();
   count_seq_if #(.WIDTH(W)) if_b ();

   assign if_a.ld_valid = ld_valid;
   assign if_a.ld_data  = ld_data;
   assign if_b.ld_valid = ld_valid;
   assign if_b.ld_data  = ld_data;

   count_seq #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut_a (
      .clk(clk), .rst(rst), .clr(clr), .start(start), .en(en), .ld(if_a),
      .cnt(cnt_a), .tc(tc_a), .ovf(ovf_a), .ovf_ack(ovf_ack));

   count_seq #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut_b (
      .clk(clk), .rst(rst), .clr(clr), .start(start), .en(en), .ld(if_b),
      .cnt(cnt_b), .tc(tc_b), .ovf(ovf_b), .ovf_ack(ovf_ack));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model, index 0 = auto-reload, index 1 = stop at all-ones.
   int           m_mode   [2];
   logic [W-1:0] m_cnt    [2];
   logic [W-1:0] m_reload [2];
   logic         m_tc     [2];
   logic         m_ovf    [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input int k, input bit auto_rl);
      bit terminal;
      bit accept;
      terminal = 1'b0;
      if (rst) begin
         m_mode[k] = M_IDLE; m_cnt[k] = '0; m_reload[k] = '0;
         m_tc[k] = 1'b0; m_ovf[k] = 1'b0;
      end else begin
         accept = ld_valid && !clr && (m_mode[k] != M_RUN);
         if (clr) begin
            m_cnt[k] = '0; m_mode[k] = M_IDLE;
         end else if (accept) begin
            m_cnt[k] = ld_data; m_reload[k] = ld_data; m_mode[k] = M_IDLE;
         end else if (m_mode[k] == M_IDLE && start) begin
            m_mode[k] = M_RUN;
         end else if (m_mode[k] == M_DONE && start) begin
            m_mode[k] = M_RUN; m_cnt[k] = m_reload[k];
         end else if (m_mode[k] == M_RUN && en) begin
            if (m_cnt[k] == MAXV) begin
               terminal = 1'b1;
               if (auto_rl) m_cnt[k] = m_reload[k];
               else         m_mode[k] = M_DONE;
            end else begin
               m_cnt[k] = W'((int'(m_cnt[k]) + 1) % 65536);
            end
         end
         m_tc[k] = terminal;
         if (terminal)     m_ovf[k] = 1'b1;
         else if (ovf_ack) m_ovf[k] = 1'b0;
      end
   endtask

   task automatic tick();
      #1;
      chk("ld_ready_a", {31'd0, if_a.ld_ready}, {31'd0, !rst && !clr && m_mode[0] != M_RUN});
      chk("ld_ready_b", {31'd0, if_b.ld_ready}, {31'd0, !rst && !clr && m_mode[1] != M_RUN});
      @(posedge clk);
      model_step(0, 1'b1);
      model_step(1, 1'b0);
      #1;
      chk("cnt_a", {16'd0, cnt_a}, {16'd0, m_cnt[0]});
      chk("cnt_b", {16'd0, cnt_b}, {16'd0, m_cnt[1]});
      chk("tc_a",  {31'd0, tc_a},  {31'd0, m_tc[0]});
      chk("tc_b",  {31'd0, tc_b},  {31'd0, m_tc[1]});
      chk("ovf_a", {31'd0, ovf_a}, {31'd0, m_ovf[0]});
      chk("ovf_b", {31'd0, ovf_b}, {31'd0, m_ovf[1]});
   endtask

   task automatic quiet();
      rst = 0; clr = 0; start = 0; en = 0; ld_valid = 0; ovf_ack = 0; ld_data = '0;
   endtask

   task automatic load_val(input logic [W-1:0] v);
      quiet(); ld_valid = 1; ld_data = v; tick();
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_mode[k] = M_IDLE; m_cnt[k] = '0; m_reload[k] = '0;
         m_tc[k] = 1'b0; m_ovf[k] = 1'b0;
      end
      quiet();
      rst = 1;
      @(negedge clk);
      tick();
      tick();
      quiet(); tick();
      chk("reset_cnt", {16'd0, cnt_a}, 32'h0);
      chk("reset_ready", {31'd0, if_a.ld_ready}, 32'h1);

      // Load, start, three enabled increments.
      load_val(16'h1234);
      chk("load_1234", {16'd0, cnt_a}, 32'h1234);
      quiet(); start = 1; tick();
      quiet(); en = 1; tick(); tick(); tick();
      chk("inc_1237_a", {16'd0, cnt_a}, 32'h1237);
      chk("inc_1237_b", {16'd0, cnt_b}, 32'h1237);
      chk("run_not_ready", {31'd0, if_a.ld_ready}, 32'h0);

      // Wrap from 0xFFFE: A reloads, B stops at all-ones.
      quiet(); clr = 1; tick();
      load_val(16'hFFFE);
      quiet(); start = 1; tick();
      quiet(); en = 1; tick();
      chk("pre_wrap", {16'd0, cnt_a}, 32'hFFFF);
      tick();
      chk("wrap_cnt_a", {16'd0, cnt_a}, 32'hFFFE);
      chk("wrap_tc_a", {31'd0, tc_a}, 32'h1);
      chk("wrap_ovf_a", {31'd0, ovf_a}, 32'h1);
      chk("stop_cnt_b", {16'd0, cnt_b}, 32'hFFFF);
      tick();
      chk("tc_one_pulse_a", {31'd0, tc_a}, 32'h0);
      // A reaches 0xFFFF again: terminal and ack coincide.
      ovf_ack = 1; tick();
      chk("ack_vs_set_ovf_a", {31'd0, ovf_a}, 32'h1);
      quiet(); ovf_ack = 1; tick();
      chk("ack_clears_ovf_a", {31'd0, ovf_a}, 32'h0);

      // Stop at 0xFFFF, then restart from reload.
      quiet(); clr = 1; tick();
      load_val(16'hFFFF);
      quiet(); start = 1; tick();
      quiet(); en = 1; tick();
      chk("done_hold_b", {16'd0, cnt_b}, 32'hFFFF);
      chk("done_tc_b", {31'd0, tc_b}, 32'h1);
      quiet(); tick();
      chk("done_tc_off_b", {31'd0, tc_b}, 32'h0);
      chk("done_ready_b", {31'd0, if_b.ld_ready}, 32'h1);
      quiet(); start = 1; tick();
      chk("restart_cnt_b", {16'd0, cnt_b}, 32'hFFFF);
      quiet(); tick();
      chk("restart_run_b", {31'd0, if_b.ld_ready}, 32'h0);

      // en toggling 1,0,1 from 0x0010.
      quiet(); clr = 1; tick();
      load_val(16'h0010);
      quiet(); start = 1; tick();
      quiet(); en = 1; tick();
      chk("tog_1", {16'd0, cnt_a}, 32'h0011);
      en = 0; tick();
      chk("tog_0", {16'd0, cnt_a}, 32'h0011);
      en = 1; tick();
      chk("tog_2", {16'd0, cnt_a}, 32'h0012);

      // clr coinciding with a terminal event.
      quiet(); clr = 1; tick();
      load_val(16'hFFFF);
      quiet(); start = 1; tick();
      quiet(); en = 1; clr = 1; tick();
      chk("clr_term_cnt", {16'd0, cnt_a}, 32'h0);
      chk("clr_term_tc", {31'd0, tc_a}, 32'h0);

      // Load and start together: load wins.
      quiet(); ld_valid = 1; ld_data = 16'hA5A5; start = 1; tick();
      chk("ld_start_cnt", {16'd0, cnt_a}, 32'hA5A5);
      quiet(); en = 1; tick();
      chk("ld_start_idle", {16'd0, cnt_a}, 32'hA5A5);
      chk("ld_start_ready", {31'd0, if_a.ld_ready}, 32'h1);

      // Randomized phase.
      for (int i = 0; i < 3000; i++) begin
         quiet();
         rst      = ($urandom_range(0, 199) == 0);
         clr      = ($urandom_range(0, 39) == 0);
         start    = ($urandom_range(0, 5) == 0);
         en       = ($urandom_range(0, 3) != 0);
         ld_valid = ($urandom_range(0, 7) == 0);
         ld_data  = ($urandom_range(0, 1) == 1) ? (16'hFFF0 | W'($urandom_range(0, 15)))
                                                : W'($urandom);
         ovf_ack  = !clr && ($urandom_range(0, 9) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
